boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_pkg.sv | 14 +
 rtl/byte_packer.sv | 53 +++++
 rtl/boot_loader.sv | 121 ++++++++++++
 tb/tb_boot_loader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared boot-sequencer definitions: loader state encodings used by CPU-side blocks.
package boot_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_LEN  = 3'd0,
        ST_DATA = 3'd1,
        ST_CSUM = 3'd2,
        ST_RUN  = 3'd3,
        ST_ERR  = 3'd4
    } boot_state_e;

endpackage

// File: rtl/byte_packer.sv
// Byte-to-word assembler, little-endian (first byte lands in bits [7:0]).
module byte_packer
    import boot_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              last_c,
    output logic [DATA_W-1:0] word_c,
    output logic              word_valid,
    output logic [DATA_W-1:0] word
);

    localparam int unsigned NB    = DATA_W / BYTE_W;
    localparam int unsigned CNT_W = $clog2(NB);
    localparam int unsigned SH_W  = DATA_W - BYTE_W;

    logic [CNT_W-1:0] cnt;
    logic [SH_W-1:0]  shift;

    // Newest byte enters at the top, so after NB bytes the first one sits at the bottom.
    assign last_c = byte_valid && (cnt == CNT_W'(NB - 1));
    assign word_c = {byte_data, shift};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            shift      <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clr) begin
                cnt   <= '0;
                shift <= '0;
            end else if (byte_valid) begin
                shift <= word_c[DATA_W-1:BYTE_W];
                if (last_c) begin
                    cnt        <= '0;
                    word       <= word_c;
                    word_valid <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Streams a length-prefixed image into instruction memory, then releases the CPU.
// Optional trailing checksum word enabled by defining BOOT_LOADER_CHECKSUM_EN.
module boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              error
);

    localparam int unsigned CNT_W = ADDR_W + 1;

`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam boot_state_e AFTER_DATA = ST_CSUM;
    logic [DATA_W-1:0] sum;
`else
    localparam boot_state_e AFTER_DATA = ST_RUN;
`endif

    boot_state_e       state, state_next;
    logic              acc_c, clr_c, last_c, last_write_c, word_valid;
    logic [DATA_W-1:0] word_c, word;
    logic [CNT_W-1:0]  n_words;

    assign acc_c        = in_valid && in_ready;
    assign clr_c        = reload && ((state == ST_RUN) || (state == ST_ERR));
    assign last_write_c = mem_we && ((CNT_W'(mem_addr) + CNT_W'(1)) == n_words);

    byte_packer #(.DATA_W(DATA_W)) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr_c),
        .byte_valid (acc_c),
        .byte_data  (in_data),
        .last_c     (last_c),
        .word_c     (word_c),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_LEN;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_LEN: begin
                if (word_valid) begin
                    if (word > DATA_W'(DEPTH))  state_next = ST_ERR;
                    else if (word == '0)        state_next = AFTER_DATA;
                    else                        state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (last_write_c) state_next = AFTER_DATA;
            end
            ST_CSUM: begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                if (word_valid) state_next = (word == sum) ? ST_RUN : ST_ERR;
`else
                state_next = ST_ERR;
`endif
            end
            ST_RUN, ST_ERR: begin
                if (reload) state_next = ST_LEN;
            end
            default: state_next = ST_ERR;
        endcase
    end

    // Status outputs track the state being entered so they line up with the state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rst_n <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            n_words   <= '0;
        end else begin
            in_ready  <= (state_next == ST_LEN) || (state_next == ST_DATA) ||
                         (state_next == ST_CSUM);
            cpu_rst_n <= (state_next == ST_RUN);
            done      <= (state_next == ST_RUN);
            error     <= (state_next == ST_ERR);
            mem_we    <= (state == ST_DATA) && last_c;
            if ((state == ST_DATA) && last_c) mem_wdata <= word_c;
            if (clr_c)       mem_addr <= '0;
            else if (mem_we) mem_addr <= mem_addr + ADDR_W'(1);
            if (clr_c)                             n_words <= '0;
            else if ((state == ST_LEN) && word_valid) n_words <= CNT_W'(word);
        end
    end

`ifdef BOOT_LOADER_CHECKSUM_EN
    // Running modulo sum of every written word, compared against the trailing word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         sum <= '0;
        else if (clr_c)  sum <= '0;
        else if (mem_we) sum <= sum + mem_wdata;
    end
`endif

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: load images, length limits, reset/reload, input gaps.
module tb_boot_loader;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 256;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              reload = 1'b0;
    logic              in_ready, mem_we, cpu_rst_n, done, error;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    always #5 clk = ~clk;

    boot_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .reload    (reload),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst_n (cpu_rst_n),
        .done      (done),
        .error     (error)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_double = 0;
    logic        we_prev  = 1'b0;
    logic [31:0] wr_data[$];
    logic [31:0] wr_addr[$];
    logic [31:0] img[$];

    // Write log sampled mid-cycle; back-to-back strobes flag a doubled write.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_data.push_back(mem_wdata);
            wr_addr.push_back(32'(mem_addr));
            if (we_prev) n_double++;
        end
        we_prev = mem_we;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        logic [31:0] v;
        v = w;
        for (int i = 0; i < 4; i++) send_byte(v[8*i +: 8], gaps);
    endtask

    task automatic send_image(input bit gaps);
        logic [31:0] s;
        s = 32'h0;
        send_word(32'(img.size()), gaps);
        foreach (img[i]) begin
            send_word(img[i], gaps);
            s = s + img[i];
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        send_word(s, gaps);
`endif
        repeat (3) @(negedge clk);
    endtask

    task automatic clear_log();
        wr_data.delete();
        wr_addr.delete();
        n_double = 0;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic check_image(input string tag);
        check({tag, "_nwr"}, 64'(wr_data.size()), 64'(img.size()));
        for (int i = 0; i < img.size() && i < wr_data.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 64'(wr_addr[i]), 64'(i));
            check($sformatf("%s_data%0d", tag, i), 64'(wr_data[i]), 64'(img[i]));
        end
        check({tag, "_double"}, 64'(n_double), 64'd0);
    endtask

    task automatic check_run(input string tag);
        check({tag, "_cpu_rst_n"}, 64'(cpu_rst_n), 64'd1);
        check({tag, "_done"},      64'(done),      64'd1);
        check({tag, "_error"},     64'(error),     64'd0);
        check({tag, "_in_ready"},  64'(in_ready),  64'd0);
    endtask

    task automatic load_basic();
        img.delete();
        img.push_back(32'h014000EF);
        img.push_back(32'hFFC10113);
        img.push_back(32'h000080E7);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_mem_we",    64'(mem_we),    64'd0);
        check("rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mem_addr",  64'(mem_addr),  64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_done",      64'(done),      64'd0);
        check("rst_error",     64'(error),     64'd0);
        check("rst_in_ready2", 64'(in_ready),  64'd1);

        // Basic three-word image
        load_basic();
        clear_log();
        send_image(1'b0);
        check_image("basic");
        check_run("basic");

        // Reload from RUN, second image overwrites from address 0
        pulse_reload();
        check("reload_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        check("reload_done",      64'(done),      64'd0);
        check("reload_in_ready",  64'(in_ready),  64'd1);
        img.delete();
        img.push_back(32'hA5A50001);
        img.push_back(32'h12345678);
        clear_log();
        send_image(1'b0);
        check_image("reimg");
        check_run("reimg");

        // Oversized length goes to ERR without writing
        pulse_reload();
        clear_log();
        send_word(32'(DEPTH + 1), 1'b0);
        repeat (4) @(negedge clk);
        check("big_error",     64'(error),          64'd1);
        check("big_in_ready",  64'(in_ready),       64'd0);
        check("big_cpu_rst_n", 64'(cpu_rst_n),      64'd0);
        check("big_done",      64'(done),           64'd0);
        check("big_nwr",       64'(wr_data.size()), 64'd0);

        // Zero-length image
        pulse_reload();
        check("err_reload_error", 64'(error), 64'd0);
        img.delete();
        clear_log();
        send_image(1'b0);
        check_image("zero");
        check_run("zero");

        // Reset mid-word, then a full image
        pulse_reload();
        send_word(32'd3, 1'b0);
        send_byte(8'hEF, 1'b0);
        send_byte(8'h00, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        @(negedge clk);
        check("rstmid_mem_we",   64'(mem_we),   64'd0);
        check("rstmid_in_ready", 64'(in_ready), 64'd1);
        load_basic();
        send_image(1'b0);
        check_image("rstmid");
        check_run("rstmid");

        // Random input gaps give identical writes
        pulse_reload();
        clear_log();
        send_image(1'b1);
        check_image("gaps");
        check_run("gaps");

        // Maximum length image
        pulse_reload();
        img.delete();
        for (int i = 0; i < DEPTH; i++) img.push_back(32'h10000000 + 32'(i) * 32'd3);
        clear_log();
        send_image(1'b0);
        check_image("full");
        check_run("full");

`ifdef BOOT_LOADER_CHECKSUM_EN
        // Checksum mismatch then match
        pulse_reload();
        clear_log();
        send_word(32'd2, 1'b0);
        send_word(32'h00000001, 1'b0);
        send_word(32'h00000002, 1'b0);
        send_word(32'h00000004, 1'b0);
        repeat (3) @(negedge clk);
        check("csum_bad_error",     64'(error),          64'd1);
        check("csum_bad_cpu_rst_n", 64'(cpu_rst_n),      64'd0);
        check("csum_bad_nwr",       64'(wr_data.size()), 64'd2);
        pulse_reload();
        clear_log();
        send_word(32'd2, 1'b0);
        send_word(32'h00000001, 1'b0);
        send_word(32'h00000002, 1'b0);
        send_word(32'h00000003, 1'b0);
        repeat (3) @(negedge clk);
        check_run("csum_ok");
        check("csum_ok_nwr", 64'(wr_data.size()), 64'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
